// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU operand/opcode widths, opcode values and the arbiter owner tag type
package fpu_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int INST_WIDTH = 1;
    localparam logic FPU_INST_ADD = 1'b0;
    localparam logic FPU_INST_MUL = 1'b1;
    typedef struct packed {
        logic valid;
        logic owner;
    } fpu_tag_t;
endpackage

// File: rtl/fpu_arb_tagpipe.sv
// fpu_arb_tagpipe: STAGES-deep shift register of {valid, owner} tags with synchronous clear
module fpu_arb_tagpipe
    import fpu_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic     i_clk,
    input  logic     i_rst,
    input  fpu_tag_t i_tag,
    output fpu_tag_t o_pre,
    output fpu_tag_t o_last,
    output logic     o_any
);
    fpu_tag_t r_stage [STAGES];
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < STAGES; k++) r_stage[k] <= '0;
        end else begin
            r_stage[0] <= i_tag;
            for (int k = 1; k < STAGES; k++) r_stage[k] <= r_stage[k-1];
        end
    end
    always_comb begin
        o_any = 1'b0;
        for (int k = 0; k < STAGES; k++) o_any = o_any | r_stage[k].valid;
    end
    assign o_pre  = r_stage[STAGES-2];
    assign o_last = r_stage[STAGES-1];
endmodule

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: two-port FPU arbiter/sequencer with owner tag pipeline; define FPU_ARB_ROUND_ROBIN_EN for
// round-robin tie-breaking, otherwise requester 0 always wins a tie.
module fpu_arbiter #(
    parameter int DATA_WIDTH = fpu_pkg::DATA_WIDTH,
    parameter int INST_WIDTH = fpu_pkg::INST_WIDTH,
    parameter int FPU_LAT    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req0_valid,
    output logic                  o_req0_ready,
    input  logic [DATA_WIDTH-1:0] i_req0_a,
    input  logic [DATA_WIDTH-1:0] i_req0_b,
    input  logic [INST_WIDTH-1:0] i_req0_inst,
    input  logic                  i_req1_valid,
    output logic                  o_req1_ready,
    input  logic [DATA_WIDTH-1:0] i_req1_a,
    input  logic [DATA_WIDTH-1:0] i_req1_b,
    input  logic [INST_WIDTH-1:0] i_req1_inst,
    output logic [DATA_WIDTH-1:0] o_fpu_a,
    output logic [DATA_WIDTH-1:0] o_fpu_b,
    output logic [INST_WIDTH-1:0] o_fpu_inst,
    output logic                  o_fpu_valid,
    input  logic [DATA_WIDTH-1:0] i_fpu_data,
    output logic                  o_resp0_valid,
    output logic                  o_resp1_valid,
    output logic [DATA_WIDTH-1:0] o_resp0_data,
    output logic [DATA_WIDTH-1:0] o_resp1_data,
    output logic                  o_busy
);
    import fpu_pkg::*;

    logic                  w_pick1;
    logic                  w_gnt0;
    logic                  w_gnt1;
    fpu_tag_t              w_tag_in;
    fpu_tag_t              w_pre;
    fpu_tag_t              w_last;
    logic [DATA_WIDTH-1:0] r_resp0_data;
    logic [DATA_WIDTH-1:0] r_resp1_data;

`ifdef FPU_ARB_ROUND_ROBIN_EN
    logic r_ptr;
    assign w_pick1 = i_req1_valid & (~i_req0_valid | r_ptr);
    // pointer names the port favoured on the next tie: the one not granted last
    always_ff @(posedge i_clk) begin
        if (i_rst) r_ptr <= 1'b0;
        else if (w_gnt0 | w_gnt1) r_ptr <= w_gnt0;
    end
`else
    assign w_pick1 = i_req1_valid & ~i_req0_valid;
`endif

    assign w_gnt1       = ~i_rst & w_pick1;
    assign w_gnt0       = ~i_rst & i_req0_valid & ~w_pick1;
    assign o_req0_ready = w_gnt0;
    assign o_req1_ready = w_gnt1;
    assign o_fpu_valid  = w_gnt0 | w_gnt1;
    assign o_fpu_a      = w_gnt1 ? i_req1_a : w_gnt0 ? i_req0_a : '0;
    assign o_fpu_b      = w_gnt1 ? i_req1_b : w_gnt0 ? i_req0_b : '0;
    assign o_fpu_inst   = w_gnt1 ? i_req1_inst : w_gnt0 ? i_req0_inst : INST_WIDTH'(FPU_INST_ADD);
    assign w_tag_in     = {o_fpu_valid, w_gnt1};

    fpu_arb_tagpipe #(.STAGES(FPU_LAT + 1)) u_tags (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_tag  (w_tag_in),
        .o_pre  (w_pre),
        .o_last (w_last),
        .o_any  (o_busy)
    );

    // the penultimate tag lines up with the FPU result; the last tag strobes the captured result
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_resp0_data <= '0;
            r_resp1_data <= '0;
        end else if (w_pre.valid) begin
            if (w_pre.owner) r_resp1_data <= i_fpu_data;
            else r_resp0_data <= i_fpu_data;
        end
    end

    assign o_resp0_valid = w_last.valid & ~w_last.owner;
    assign o_resp1_valid = w_last.valid & w_last.owner;
    assign o_resp0_data  = r_resp0_data;
    assign o_resp1_data  = r_resp1_data;
endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: randomized scoreboard bench for fpu_arbiter with a behavioural FPU and arbitration model
module tb_fpu_arbiter;
    localparam int LAT = 1;
`ifdef FPU_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [0:0]  n0 = '0, n1 = '0;
    logic        rdy0, rdy1, fvalid, rv0, rv1, busy;
    logic [31:0] fa, fb, fdata, rd0, rd1;
    logic [0:0]  finst;
    logic [31:0] fpipe [LAT];

    always #5 clk = ~clk;

    fpu_arbiter #(.DATA_WIDTH(32), .INST_WIDTH(1), .FPU_LAT(LAT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0), .o_req0_ready(rdy0), .i_req0_a(a0), .i_req0_b(b0), .i_req0_inst(n0),
        .i_req1_valid(v1), .o_req1_ready(rdy1), .i_req1_a(a1), .i_req1_b(b1), .i_req1_inst(n1),
        .o_fpu_a(fa), .o_fpu_b(fb), .o_fpu_inst(finst), .o_fpu_valid(fvalid), .i_fpu_data(fdata),
        .o_resp0_valid(rv0), .o_resp1_valid(rv1), .o_resp0_data(rd0), .o_resp1_data(rd1),
        .o_busy(busy)
    );

    function automatic logic [31:0] fn(logic [31:0] a, logic [31:0] b, logic op);
        return op ? a * b : a + b;
    endfunction

    // stand-in FPU: result of the sampled operation appears LAT cycles later, garbage otherwise
    always @(posedge clk) begin
        fpipe[0] <= fvalid ? fn(fa, fb, finst[0]) : $urandom;
        for (int i = LAT - 1; i > 0; i--) fpipe[i] <= fpipe[i-1];
    end
    assign fdata = fpipe[LAT-1];

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    exp_t        q0[$], q1[$];
    exp_t        e;
    int          ntot = 0, npass = 0, cyc = 0, last_acc = -1000, gcnt1 = 0, snap;
    bit          next1 = 1'b0, acc0 = 1'b0, acc1 = 1'b0, w1, g0, g1;
    logic [31:0] last_d0 = '0, last_d1 = '0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (cyc > 0) begin
        if (rst) begin
            chk("rst_ready", {rdy0, rdy1}, 0);
            chk("rst_fpu_valid", fvalid, 0);
            chk("rst_fpu_ops", {fa, fb}, 0);
            chk("rst_fpu_inst", finst, 0);
            chk("rst_resp_valid", {rv0, rv1}, 0);
            q0.delete(); q1.delete();
            last_acc = -1000; next1 = 1'b0; last_d0 = '0; last_d1 = '0; acc0 = 1'b0; acc1 = 1'b0;
        end else begin
            chk("busy", busy, (cyc - last_acc) <= LAT + 1);
            w1 = (v0 && v1) ? (RR && next1) : v1;
            g1 = v1 && w1;
            g0 = v0 && !g1;
            chk("ready0", rdy0, g0);
            chk("ready1", rdy1, g1);
            chk("fpu_valid", fvalid, g0 || g1);
            chk("fpu_ops", {fa, fb}, g1 ? {a1, b1} : g0 ? {a0, b0} : 64'd0);
            chk("fpu_inst", finst, g1 ? n1 : g0 ? n0 : 1'b0);
            if (rdy1) gcnt1++;
            if (g0) begin
                q0.push_back('{fn(a0, b0, n0[0]), cyc + LAT + 1});
                acc0 = 1'b1; next1 = 1'b1; last_acc = cyc;
            end
            if (g1) begin
                q1.push_back('{fn(a1, b1, n1[0]), cyc + LAT + 1});
                acc1 = 1'b1; next1 = 1'b0; last_acc = cyc;
            end
            if (rv0) begin
                if (q0.size() == 0) chk("resp0_spurious", 1, 0);
                else begin
                    e = q0.pop_front();
                    chk("resp0_data", rd0, e.d);
                    chk("resp0_cycle", cyc, e.due);
                    last_d0 = e.d;
                end
            end else begin
                chk("resp0_hold", rd0, last_d0);
                if (q0.size() > 0 && q0[0].due <= cyc) begin
                    chk("resp0_missing", 0, 1);
                    void'(q0.pop_front());
                end
            end
            if (rv1) begin
                if (q1.size() == 0) chk("resp1_spurious", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("resp1_data", rd1, e.d);
                    chk("resp1_cycle", cyc, e.due);
                    last_d1 = e.d;
                end
            end else begin
                chk("resp1_hold", rd1, last_d1);
                if (q1.size() > 0 && q1[0].due <= cyc) begin
                    chk("resp1_missing", 0, 1);
                    void'(q1.pop_front());
                end
            end
        end
    end

    // one cycle of requester behaviour: hold until accepted, then raise a fresh op with probability p
    task automatic step(int p0, int p1);
        @(posedge clk); #1;
        if (acc0 || !v0) begin
            acc0 = 1'b0;
            v0 = $urandom_range(1, 100) <= p0;
            a0 = $urandom; b0 = $urandom; n0 = 1'($urandom_range(0, 1));
        end
        if (acc1 || !v1) begin
            acc1 = 1'b0;
            v1 = $urandom_range(1, 100) <= p1;
            a1 = $urandom; b1 = $urandom; n1 = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic put0(logic [31:0] a, logic [31:0] b, logic n);
        v0 = 1'b1; a0 = a; b0 = b; n0 = n;
        @(posedge clk); #1;
        acc0 = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        v0 = 1'b1; a0 = 32'h3F800000; b0 = 32'h40000000; n0 = 1'b0;
        repeat (5) step(0, 0);
        v1 = 1'b1; a1 = 32'h40000000; b1 = 32'h40400000; n1 = 1'b1;
        repeat (5) step(0, 0);
        v0 = 1'b1; v1 = 1'b1;
        snap = gcnt1;
        repeat (6) step(100, 100);
        chk("tie_grants_port1", gcnt1 - snap, RR ? 3 : 0);
        repeat (8) step(0, 0);
        put0(32'h3F800000, 32'h3F800000, 1'b0);
        put0(32'h3FC00000, 32'h40000000, 1'b1);
        put0(32'h40000000, 32'h40000000, 1'b0);
        v0 = 1'b0;
        repeat (5) step(0, 0);
        put0(32'h12345678, 32'h00000010, 1'b0);
        v1 = 1'b1; a1 = 32'h0000_0003; b1 = 32'h0000_0005; n1 = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) step(0, 0);
        repeat (3000) step($urandom_range(20, 100), $urandom_range(20, 100));
        for (int i = 0; i < 100 && (v0 || v1 || q0.size() > 0 || q1.size() > 0); i++) step(0, 0);
        if (v0 || v1 || q0.size() > 0 || q1.size() > 0) chk("drain_timeout", 0, 1);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Two-requester arbiter and sequencer for the shared single-precision FPU (adder/multiplier datapath, 1-bit instruction select). It accepts operand pairs from two independent requesters over valid/ready handshakes, issues at most one operation per cycle into the FPU, and tracks each in-flight operation's owner through a tag pipeline matched to the FPU latency. It routes each result back to the requester that issued it. It sits between the FPU and its clients, for example a scalar core port and a DMA/vector port.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width
- INST_WIDTH, 1, FPU instruction width (0 = add, 1 = mul)
- FPU_LAT, 1, cycles from FPU input sampling edge to result visible on i_fpu_data; legal range 1..8

Ports. One clock; reset is synchronous and active-high (i_clk, i_rst).
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_req0_valid  in  1  requester 0 has an operation
- o_req0_ready  out  1  requester 0 operation accepted this cycle
- i_req0_a, i_req0_b  in  DATA_WIDTH  requester 0 operands
- i_req0_inst  in  INST_WIDTH  requester 0 opcode
- i_req1_valid, o_req1_ready, i_req1_a, i_req1_b, i_req1_inst  same as requester 0, for requester 1
- o_fpu_a, o_fpu_b  out  DATA_WIDTH  FPU operands
- o_fpu_inst  out  INST_WIDTH  FPU opcode
- o_fpu_valid  out  1  operation issued this cycle
- i_fpu_data  in  DATA_WIDTH  FPU result
- o_resp0_valid, o_resp1_valid  out  1  one-cycle result strobe per requester
- o_resp0_data, o_resp1_data  out  DATA_WIDTH  registered result per requester
- o_busy  out  1  any operation in flight

## Operation
- Grant logic is combinational from the two valids and a 1-bit priority pointer.
- o_reqK_ready = grant[K]. At most one ready is high per cycle. Ready never depends on the requester's own ready.
- Transfer occurs when valid & ready at a posedge. A requester holds a, b, inst stable while valid is high without ready.
- o_fpu_a/b/inst are muxed combinationally from the granted port. o_fpu_valid = |grant. When nothing is granted, operand outputs are driven to 0.
- Tag pipeline: FPU_LAT+1 stages of {valid, owner}. Stage 0 loads {|grant, grant[1]}. Each stage shifts every cycle, with no stall.
- Final stage valid: i_fpu_data is registered into o_respK_data of the owner, and o_respK_valid pulses for one cycle. The other port's data register holds its old value.
- Responses are never back-pressured. Requesters sink one result per cycle.
- Sustained throughput: one issue per cycle, with results returned in issue order.
- o_busy = OR of all tag-stage valids.
- Both valid with round-robin enabled: grant the port the pointer selects. After any grant to port K, the pointer moves to the other port. A single valid requester is always granted regardless of pointer.
- Reset mid-operation: all tag stages are cleared, in-flight results are discarded (no resp strobes), and the pointer is set to port 0.

## Timing
- Reset values: o_req0_ready = o_req1_ready = 0 during i_rst; o_fpu_valid = 0; o_fpu_a = o_fpu_b = 0; o_fpu_inst = 0; o_resp0/1_valid = 0; o_resp0/1_data = 0; o_busy = 0.
- Handshake at edge ending cycle t means FPU inputs are valid during cycle t.
- Result visible on i_fpu_data in cycle t+FPU_LAT.
- o_respK_valid/data asserted in cycle t+FPU_LAT+1.
- Total latency, accept to response: FPU_LAT+1 cycles (2 for the default).
- Ready is combinational from valid in the same cycle; there is no extra accept cycle.
- Back-to-back issue from alternating ports produces responses on alternating cycles, in the same order.

## Configuration
- FPU_ARB_ROUND_ROBIN_EN defined: round-robin priority pointer as in Operation.
- FPU_ARB_ROUND_ROBIN_EN undefined: fixed priority, with requester 0 always winning a tie. The pointer register is not built, and requester 1 can starve.

## Structure
- Shared package fpu_pkg:
  - DATA_WIDTH and INST_WIDTH constants
  - FPU_INST_ADD = 1'b0 and FPU_INST_MUL = 1'b1
  - typedef fpu_tag_t = {valid, owner}
- Sub-module fpu_arb_tagpipe: a parameterized FPU_LAT+1-stage shift register of fpu_tag_t with synchronous clear.
- Top level contains grant, mux, pointer and response registers.

## Test plan
- Single request: req0 a=0x3F800000, b=0x40000000, inst=0 (add) -> o_fpu_valid one cycle; o_resp0_valid 2 cycles after accept with 0x40400000; o_resp1_valid stays 0.
- Multiply on port 1: a=0x40000000, b=0x40400000, inst=1 -> o_resp1_data = 0x40C00000 at accept+2; o_busy high for 2 cycles.
- Both valid continuously for 6 cycles (round-robin) -> grants alternate 0,1,0,1,0,1; resp strobes alternate in the same order. Without the macro: six grants to port 0, none to port 1.
- Back-to-back: port 0 issues 3 ops in consecutive cycles (1.0+1.0, 1.5*2.0, 2.0+2.0) -> resp0 on 3 consecutive cycles: 0x40000000, 0x40400000, 0x40800000.
- Reset mid-flight: accept an op, assert i_rst in the next cycle -> no resp strobe ever appears; all outputs hold reset values; first grant after reset goes to port 0 on a tie.
- FPU_LAT=3 build: a single add -> response at accept+4; issue every cycle yields one response per cycle.
